// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between the UART receive port and
// the bus side. Circular FIFO with show-ahead output, occupancy count,
// watermark interrupt and a sticky overflow flag for bytes dropped when full.
// Upstream is never back-pressured: once out of reset in_ready stays high,
// and a byte that arrives while the FIFO is full is discarded.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  input  logic [$clog2(DEPTH+1)-1:0] threshold,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       irq,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_in_ready;
  logic             r_irq;
  logic             r_overflow;

  logic             w_out_valid;
  logic             w_full;
  logic             w_push_req;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [CW-1:0]    w_count_next;

  // Handshake decode. in_ready is a register, so nothing here loops back
  // into the upstream valid. A push into a full FIFO is still accepted when
  // a pop frees a slot in the same cycle.
  assign w_out_valid = (r_count != '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_push_req  = in_valid & r_in_ready;
  assign w_pop       = w_out_valid & out_ready;
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_drop      = w_push_req & w_full & ~w_pop & ~flush;

  // Next occupancy; flush wins over any push or pop in the same cycle.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_count_next = r_count;
    if (flush) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Pointers, occupancy, in_ready, watermark interrupt and sticky overflow.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
      r_irq      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_in_ready <= 1'b1;
      r_count    <= w_count_next;
      r_irq      <= (w_count_next >= threshold) && (threshold != '0);
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Storage write port; contents are only meaningful between rd and wr pointers.
  always_ff @(posedge CLK) begin
    // NOTE: the array has no reset; count and pointers define which entries are valid.
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign irq       = r_irq;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic             CLK = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             flush = 1'b0;
  logic [CW-1:0]    threshold = '0;
  logic [CW-1:0]    count;
  logic             irq;
  logic             overflow;
  logic             clr_overflow = 1'b0;

  always #5 CLK = ~CLK;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .flush        (flush),
    .threshold    (threshold),
    .count        (count),
    .irq          (irq),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: a queue of stored bytes plus the three flags.
  logic [WIDTH-1:0] m_q [$];
  bit               m_ovf = 1'b0;
  bit               m_irq = 1'b0;
  bit               m_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_irq = 1'b0;
    m_rdy = 1'b0;
  endtask

  // What one rising edge does, from the current inputs.
  task automatic model_edge();
    bit push_req;
    bit pop;
    bit drop;
    if (!reset) return;
    push_req = in_valid && m_rdy;
    pop      = (m_q.size() != 0) && out_ready;
    drop     = 1'b0;
    if (flush) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push_req) begin
        if (m_q.size() < DEPTH) m_q.push_back(in_data);
        else drop = 1'b1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
    m_irq = (threshold != 0) && (m_q.size() >= int'(threshold));
    m_rdy = 1'b1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),  32'(m_rdy));
    check({tag, ".count"},     32'(count),     32'(m_q.size()));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
    check({tag, ".irq"},       32'(irq),       32'(m_irq));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    if (m_q.size() != 0) check({tag, ".out_data"}, 32'(out_data), 32'(m_q[0]));
  endtask

  // Inputs change 1 time unit after each rising edge; outputs are sampled there too.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic push_byte(input logic [WIDTH-1:0] d, input string tag);
    in_valid = 1'b1;
    in_data  = d;
    cycle(tag);
    in_valid = 1'b0;
  endtask

  task automatic pop_one(input string tag);
    out_ready = 1'b1;
    cycle(tag);
    out_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2 && m_q.size() != 0; i++) pop_one(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] last;
    int pushed;
    int guard;
    bit do_push;
    bit do_pop;

    // Reset held: every output at its reset value.
    model_reset();
    #12;
    check_all("reset");
    @(posedge CLK);
    #1;
    reset = 1'b1;
    cycle("release");

    // Single byte: visible one cycle after the push, then popped.
    push_byte(8'h55, "t1_push");
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data",  32'(out_data),  32'h55);
    check("t1_count", 32'(count),     32'd1);
    pop_one("t1_pop");
    check("t1_empty", 32'(out_valid), 32'd0);
    check("t1_count0", 32'(count),    32'd0);

    // Fill with threshold=0, then overflow on one more byte.
    threshold = '0;
    for (int i = 0; i < DEPTH; i++) begin
      push_byte(WIDTH'(i), "t2_fill");
      check("t2_irq_off", 32'(irq), 32'd0);
    end
    push_byte(8'hAA, "t2_drop");
    check("t2_count", 32'(count),    32'd16);
    check("t2_ovf",   32'(overflow), 32'd1);
    check("t2_rdy",   32'(in_ready), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_order", 32'(out_data), 32'(i));
      pop_one("t2_pop");
    end
    check("t2_empty", 32'(out_valid), 32'd0);

    // Full plus simultaneous push and pop: accepted, no overflow.
    clr_overflow = 1'b1;
    cycle("t3_clr");
    clr_overflow = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_byte(WIDTH'(8'h30 + i), "t3_fill");
    in_valid  = 1'b1;
    in_data   = 8'h77;
    out_ready = 1'b1;
    cycle("t3_both");
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t3_count", 32'(count),    32'd16);
    check("t3_ovf",   32'(overflow), 32'd0);
    last = '0;
    for (int i = 0; i < DEPTH + 2 && m_q.size() != 0; i++) begin
      last = out_data;
      pop_one("t3_drain");
    end
    check("t3_last", 32'(last), 32'h77);

    // Pointer wrap: 40 bytes with occupancy kept between 1 and 5.
    pushed = 0;
    guard  = 0;
    while ((pushed < 40) && (guard < 1000)) begin
      guard++;
      do_push = (m_q.size() < 5) && ((m_q.size() == 0) || ($urandom % 2 == 1));
      do_pop  = (m_q.size() == 5) || ((m_q.size() >= 2) && ($urandom % 2 == 1));
      in_valid  = do_push;
      in_data   = WIDTH'($urandom);
      out_ready = do_pop;
      if (do_push) pushed++;
      cycle("t4_wrap");
    end
    check("t4_done", 32'(pushed), 32'd40);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drain("t4_drain");

    // Watermark at 4.
    threshold = CW'(4);
    for (int i = 0; i < 3; i++) begin
      push_byte(WIDTH'(8'hC0 + i), "t5_push");
      check("t5_irq_lo", 32'(irq), 32'd0);
    end
    push_byte(8'hC3, "t5_push4");
    check("t5_irq_hi", 32'(irq), 32'd1);
    pop_one("t5_pop");
    check("t5_irq_pop", 32'(irq), 32'd0);
    drain("t5_drain");
    threshold = '0;

    // Flush with a simultaneous push leaves overflow alone.
    for (int i = 0; i <= DEPTH; i++) push_byte(WIDTH'(i), "t6_ovf");
    check("t6_ovf_set", 32'(overflow), 32'd1);
    flush = 1'b1;
    cycle("t6_flush0");
    flush = 1'b0;
    for (int i = 0; i < 7; i++) push_byte(WIDTH'(8'h60 + i), "t6_fill7");
    check("t6_count7", 32'(count), 32'd7);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    cycle("t6_flush");
    flush    = 1'b0;
    in_valid = 1'b0;
    check("t6_count", 32'(count),     32'd0);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_ovf",   32'(overflow),  32'd1);

    // Drop and clear in the same cycle: set wins.
    clr_overflow = 1'b1;
    cycle("t7_clr");
    clr_overflow = 1'b0;
    check("t7_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) push_byte(WIDTH'(i), "t7_fill");
    clr_overflow = 1'b1;
    push_byte(8'hBB, "t7_drop_clr");
    clr_overflow = 1'b0;
    check("t7_ovf", 32'(overflow), 32'd1);
    flush = 1'b1;
    cycle("t7_flush");
    flush = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) threshold = CW'($urandom_range(0, DEPTH));
      in_valid     = ($urandom % 4) != 0;
      in_data      = WIDTH'($urandom);
      out_ready    = ($urandom % 3) == 0 || (i >= 200 && ($urandom % 2 == 1));
      flush        = ($urandom % 40) == 0;
      clr_overflow = ($urandom % 16) == 0;
      cycle("rand");
    end
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    flush        = 1'b0;
    clr_overflow = 1'b0;

    // Asynchronous reset mid-stream, with a byte arriving during reset.
    threshold = CW'(2);
    for (int i = 0; i < 3; i++) push_byte(WIDTH'(8'h90 + i), "t8_pre");
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("t8_async");
    check("t8_rdy0", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    @(posedge CLK);
    #1;
    check_all("t8_held");
    reset = 1'b1;
    cycle("t8_release");
    in_valid = 1'b0;
    check("t8_lost", 32'(count), 32'd0);
    push_byte(8'h3C, "t8_after");
    check("t8_data", 32'(out_data), 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
